// File: rtl/usb_nrzi_line_encoder.sv
// rtl/usb_nrzi_line_encoder.sv - USB NRZI line encoder with bit timing and EOP generation (optional SYNC via USB_TX_SYNC_GEN_EN)
module usb_nrzi_line_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_start,
    input  logic tx_data_bit,
    input  logic stuff_bit,
    input  logic eop_req,
    output logic shift_strobe,
    output logic d_plus,
    output logic d_minus,
    output logic tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef USB_TX_SYNC_GEN_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DATA    = 3'd1,
        S_EOP_SE0 = 3'd2,
        S_EOP_J   = 3'd3,
        S_SYNC    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DATA    = 3'd1,
        S_EOP_SE0 = 3'd2,
        S_EOP_J   = 3'd3
    } state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          line, line_n;       // 1 = J, 0 = K
    logic          se0_second, se0_n;  // set during the second SE0 bit period
    logic          boundary;
    logic          bit_val;
    logic          dp_n, dm_n;
`ifdef USB_TX_SYNC_GEN_EN
    logic [2:0]    sync_idx, sync_idx_n;
`endif

    assign boundary = (cnt == CNT_LAST);
    assign bit_val  = stuff_bit ? 1'b0 : tx_data_bit;
    assign tx_busy  = (state != S_IDLE);

    // Next-state, next-line and Mealy shift_strobe decode
    always_comb begin
        state_n      = state;
        cnt_n        = boundary ? '0 : cnt + CW'(1);
        line_n       = line;
        se0_n        = se0_second;
        shift_strobe = 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
        sync_idx_n   = sync_idx;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                se0_n = 1'b0;
                if (tx_start) begin
`ifdef USB_TX_SYNC_GEN_EN
                    // First SYNC bit is a 0, so the line toggles
                    state_n    = S_SYNC;
                    line_n     = ~line;
                    sync_idx_n = 3'd0;
`else
                    state_n      = S_DATA;
                    line_n       = bit_val ? line : ~line;
                    shift_strobe = ~stuff_bit;
`endif
                end
            end
            S_DATA: begin
                if (boundary) begin
                    if (stuff_bit) begin
                        // Stuffed 0 always goes out before any EOP
                        line_n = ~line;
                    end else if (eop_req) begin
                        state_n = S_EOP_SE0;
                        se0_n   = 1'b0;
                    end else begin
                        line_n       = tx_data_bit ? line : ~line;
                        shift_strobe = 1'b1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (boundary) begin
                    if (se0_second) begin
                        state_n = S_EOP_J;
                        se0_n   = 1'b0;
                    end else begin
                        se0_n = 1'b1;
                    end
                end
            end
            S_EOP_J: begin
                if (boundary) begin
                    state_n = S_IDLE;
                    line_n  = 1'b1;
                end
            end
`ifdef USB_TX_SYNC_GEN_EN
            S_SYNC: begin
                if (boundary) begin
                    if (sync_idx == 3'd7) begin
                        // Boundary ending the last SYNC bit samples the first data bit
                        state_n      = S_DATA;
                        line_n       = tx_data_bit ? line : ~line;
                        shift_strobe = 1'b1;
                    end else begin
                        // SYNC bits 1..6 are 0 (toggle), bit 7 is 1 (hold)
                        sync_idx_n = sync_idx + 3'd1;
                        line_n     = (sync_idx == 3'd6) ? line : ~line;
                    end
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
                line_n  = 1'b1;
                cnt_n   = '0;
            end
        endcase
    end

    // Line levels derived from the next state and next line value
    always_comb begin
        dp_n = line_n;
        dm_n = ~line_n;
        case (state_n)
            S_IDLE:    begin dp_n = 1'b1; dm_n = 1'b0; end
            S_EOP_SE0: begin dp_n = 1'b0; dm_n = 1'b0; end
            S_EOP_J:   begin dp_n = 1'b1; dm_n = 1'b0; end
            default:   begin dp_n = line_n; dm_n = ~line_n; end
        endcase
    end

    // State, counter, line and registered output pair
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            line       <= 1'b1;
            se0_second <= 1'b0;
            d_plus     <= 1'b1;
            d_minus    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            line       <= line_n;
            se0_second <= se0_n;
            d_plus     <= dp_n;
            d_minus    <= dm_n;
        end
    end

`ifdef USB_TX_SYNC_GEN_EN
    // SYNC bit index register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_idx <= 3'd0;
        end else begin
            sync_idx <= sync_idx_n;
        end
    end
`endif

endmodule

// File: tb/tb_usb_nrzi_line_encoder.sv
// tb/tb_usb_nrzi_line_encoder.sv - randomized model-based bench for usb_nrzi_line_encoder
module tb_usb_nrzi_line_encoder;

    localparam int CPB  = 8;
    localparam int MAXC = 32768;
    localparam int MAXP = 1024;

    logic clk = 1'b0;
    logic rst, tx_start, tx_data_bit, stuff_bit, eop_req;
    logic shift_strobe, d_plus, d_minus, tx_busy;

    usb_nrzi_line_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data_bit(tx_data_bit),
        .stuff_bit(stuff_bit), .eop_req(eop_req), .shift_strobe(shift_strobe),
        .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per absolute cycle
    bit ev[MAXC], edp[MAXC], edm[MAXC], est[MAXC], ebz[MAXC];
    // Input schedule per packet-relative cycle
    bit i_start[MAXP], i_data[MAXP], i_stuff[MAXP], i_eop[MAXP], i_rst[MAXP];

    int checks = 0;
    int errors = 0;
    int plen, last_e;
    bit pd[$];
    bit ps[$];

    task automatic chk(input string nm, input int at, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, at, act, req);
        end
    endtask

    // Compare process: every cycle with a defined expectation
    always @(negedge clk) begin
        if (cyc < MAXC && ev[cyc]) begin
            chk("d_plus", cyc, d_plus, edp[cyc]);
            chk("d_minus", cyc, d_minus, edm[cyc]);
            chk("shift_strobe", cyc, shift_strobe, est[cyc]);
            chk("tx_busy", cyc, tx_busy, ebz[cyc]);
        end
    end

    task automatic set_exp(input int a, input bit dp, input bit dm, input bit bz);
        if (a < MAXC) begin
            ev[a] = 1; edp[a] = dp; edm[a] = dm; ebz[a] = bz; est[a] = 0;
        end
    endtask

    // Model: decision j happens at packet cycle j*CPB; its bit is shown on
    // cycles j*CPB+1 .. (j+1)*CPB. Line starts at J, a 0 toggles it.
    task automatic build(input int base, input int rst_at);
        int n = pd.size();
        int idx = 0;
        int j = 0;
        int cb;
        bit line = 1;
        bit fin = 0;
        bit s;
        int e = 0;
        for (int c = 0; c < MAXP; c++) begin
            i_start[c] = ($urandom_range(7) == 0);
            i_data[c]  = 1'($urandom);
            i_stuff[c] = 1'($urandom);
            i_eop[c]   = 1'($urandom);
            i_rst[c]   = 0;
        end
        i_start[0] = 1;
        set_exp(base, 1, 0, 0);
        while (!fin) begin
            cb = j * CPB;
            s = (j < ps.size()) ? ps[j] : 1'b0;
            i_stuff[cb] = s;
            i_eop[cb]   = (idx == n);
            i_data[cb]  = (idx < n) ? pd[idx] : 1'($urandom);
            if (s) begin
                line = ~line;
            end else if (idx == n && j > 0) begin
                fin = 1;
                e = cb;
            end else begin
                if (!pd[idx]) line = ~line;
                est[base + cb] = 1;
                idx++;
            end
            if (!fin)
                for (int k = 1; k <= CPB; k++) set_exp(base + cb + k, line, !line, 1);
            j++;
        end
        for (int k = 1; k <= 2 * CPB; k++) set_exp(base + e + k, 0, 0, 1);
        for (int k = 2 * CPB + 1; k <= 3 * CPB; k++) set_exp(base + e + k, 1, 0, 1);
        set_exp(base + e + 3 * CPB + 1, 1, 0, 0);
        plen = e + 3 * CPB + 1;
        last_e = e;
        if (rst_at > 0) begin
            i_rst[rst_at] = 1;
            for (int c = rst_at + 2; c <= plen; c++) ev[base + c] = 0;
            set_exp(base + rst_at + 1, 1, 0, 0);
            plen = rst_at + 1;
        end
        i_start[plen] = 0;
    endtask

    task automatic run_packet();
        for (int c = 0; c <= plen; c++) begin
            tx_start    = i_start[c];
            tx_data_bit = i_data[c];
            stuff_bit   = i_stuff[c];
            eop_req     = i_eop[c];
            rst         = i_rst[c];
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int nc);
        for (int c = 0; c < nc; c++) begin
            set_exp(cyc, 1, 0, 0);
            tx_start    = 0;
            tx_data_bit = 1'($urandom);
            stuff_bit   = 1'($urandom);
            eop_req     = 1'($urandom);
            rst         = 0;
            @(posedge clk); #1;
        end
    endtask

    int base, r, nb, np;

    initial begin
        rst = 1; tx_start = 0; tx_data_bit = 0; stuff_bit = 0; eop_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle(20);

        // Data 0,0,1,0 -> K,J,J,K then SE0 x16, J x8, idle
        pd = '{0, 0, 1, 0}; ps = '{};
        base = cyc; build(base, 0);
        chk("pin_k1", base + 8, edm[base + 8], 1);
        chk("pin_j2", base + 9, edm[base + 9], 0);
        chk("pin_j3", base + 24, edp[base + 24], 1);
        chk("pin_k4", base + 25, edm[base + 25], 1);
        chk("pin_se0_first", base + 33, {edp[base + 33], edm[base + 33]}, 0);
        chk("pin_se0_last", base + 48, {edp[base + 48], edm[base + 48]}, 0);
        chk("pin_eop_j", base + 49, {edp[base + 49], edm[base + 49]}, 2);
        chk("pin_busy_last", base + 56, ebz[base + 56], 1);
        chk("pin_busy_drop", base + 57, ebz[base + 57], 0);
        chk("pin_strobe_start", base, est[base], 1);
        chk("pin_strobe_b3", base + 24, est[base + 24], 1);
        chk("pin_no_strobe_eop", base + 32, est[base + 32], 0);
        run_packet();
        idle(2);

        // Data 0,1,1 -> K held 24 cycles
        pd = '{0, 1, 1}; ps = '{};
        base = cyc; build(base, 0);
        chk("pin_k_hold", base + 24, edm[base + 24], 1);
        run_packet();
        idle(1);

        // Stuff at boundary 1 with data bit 1 presented
        pd = '{0, 1, 0}; ps = '{0, 1};
        base = cyc; build(base, 0);
        chk("pin_stuff_nostrobe", base + 8, est[base + 8], 0);
        chk("pin_stuff_toggle", base + 9, edp[base + 9], 1);
        chk("pin_stuff_consume", base + 16, est[base + 16], 1);
        run_packet();
        idle(1);

        // EOP requested together with a stuff: stuff first, SE0 one period later
        pd = '{1}; ps = '{0, 1};
        base = cyc; build(base, 0);
        chk("pin_stuff_before_eop", base + 16, edm[base + 16], 1);
        chk("pin_se0_after_stuff", base + 17, {edp[base + 17], edm[base + 17]}, 0);
        run_packet();
        idle(1);

        // Reset mid-DATA while K is on the lines
        pd = '{0, 1, 1, 1}; ps = '{};
        base = cyc; build(base, 12);
        chk("pin_rst_k", base + 12, edm[base + 12], 1);
        chk("pin_rst_j", base + 13, edp[base + 13], 1);
        run_packet();
        idle(3);

        // tx_start during EOP_SE0 is ignored
        pd = '{1, 0}; ps = '{};
        base = cyc; build(base, 0);
        i_start[last_e + 4] = 1;
        run_packet();
        idle(2);

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            pd = '{}; ps = '{};
            nb = $urandom_range(10, 1);
            for (int i = 0; i < nb; i++) pd.push_back(1'($urandom));
            np = $urandom_range(20, 1);
            for (int i = 0; i < np; i++) ps.push_back($urandom_range(3) == 0);
            base = cyc;
            build(base, 0);
            if ($urandom_range(5) == 0) begin
                r = $urandom_range(plen - 1, 1);
                if (r % CPB == 0) r = r + 1;
                if (r < plen) build(base, r);
            end
            run_packet();
            idle($urandom_range(3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
